mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Unified instruction/data memory slave that sits on the far side of the multicycle core's memory port.
- Accepts one word-sized read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns read data or a write acknowledgement over a second valid/ready handshake.
- Flags misaligned and out-of-range accesses with an error bit instead of touching storage.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on req_addr.
- DEPTH_WORDS, 1024, number of 32-bit words of storage; word index = req_addr >> 2.
- WAIT_CYCLES, 2, extra wait states before the access commits; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables for stores; bit i enables byte i ([8i+7:8i]).
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_error  output  1  access was misaligned or out of range.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, any time):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_error=0, busy=0; req_ready=1 once reset deasserts.
  - Storage is neither cleared nor initialised.
  - A pending store that has not yet committed is dropped.
- States: IDLE, WAIT, RESP. req_ready is high only in IDLE (combinational from state).
- IDLE:
  - On a clk edge with req_valid && req_ready, latch addr/wdata/wstrb/write.
  - Load wait counter = WAIT_CYCLES and go to WAIT.
  - Request inputs are ignored in all other states.
- WAIT:
  - If counter != 0, decrement it and stay in WAIT.
  - If counter == 0, perform the access on this edge and go to RESP.
- Latency: request accepted at edge N gives resp_valid high from edge N+1+WAIT_CYCLES. For WAIT_CYCLES=0 this is 1 cycle.
- Error check, evaluated on latched addr:
  - Error if addr[1:0] != 0 or (addr >> 2) >= DEPTH_WORDS.
  - On error: no storage write, resp_rdata=0, resp_error=1.
- Load: resp_rdata = mem[addr>>2], registered at commit; resp_error=0.
- Store:
  - For each i, byte i of mem[addr>>2] is replaced by wdata byte i only if wstrb[i]=1.
  - wstrb=0 is a legal no-op with no error.
  - resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable until the handshake.
  - On an edge with resp_ready=1: go to IDLE and clear resp_valid, resp_rdata and resp_error to 0.
  - No new request is accepted in the same cycle as the response handshake; minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Stores commit exactly once per accepted request, regardless of how long the response is back-pressured.
- Loads of never-written words return unknown contents; benches must write before reading.

Test Plan:
1. WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then load 0x10. Required: each resp_valid arrives 3 cycles after accept; load returns 0xDEADBEEF with resp_error=0.
2. Partial store: after case 1, store addr 0x10, wdata 0x000000AA, wstrb 0x1. Required: a following load returns 0xDEADBEAA.
3. Misaligned and out-of-range:
   - Load 0x12 → resp_error=1, rdata=0.
   - Store 0x1000 (word 1024, DEPTH 1024) → resp_error=1, rdata=0.
   - A subsequent load of 0x10 still returns the prior value (no corruption).
4. Back-pressure: hold resp_ready=0 for 5 cycles during a load response. Required: resp_valid, rdata and error stay stable; req_ready stays 0; a req_valid pulse in this window is ignored; the handshake then returns the FSM to IDLE.
5. Reset mid-WAIT: assert reset while a store to 0x20 (wdata 0x12345678) is in WAIT with counter>0. Required: outputs are 0 immediately (async); after release, a load of 0x20 does not return 0x12345678 (pre-written with 0x0 beforehand).
6. WAIT_CYCLES=0 build: accept a load at edge N. Required: resp_valid is high after edge N+1; busy is high for exactly the WAIT and RESP cycles.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-wide unified memory slave with a request handshake,
// a fixed number of wait states, and a registered response handshake.
// Misaligned or out-of-range accesses return an error and leave storage untouched.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ready for a request; response outputs are zero
// S_WAIT | request latched; wait counter running, access at zero
// S_RESP | response presented; held until resp_ready

module mem_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_wstrb,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic                  busy
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            cnt_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic [31:0]           rdata_q;
   logic                  error_q;
   logic [31:0]           mem [DEPTH_WORDS];

   logic                  accept;
   logic                  commit;
   logic                  resp_done;
   logic                  access_err;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [IDX_W-1:0]      mem_idx;

   // Word index and legality of the latched address; the comparison is one
   // bit wider than the index so DEPTH_WORDS itself is representable.
   always_comb begin
      word_idx   = addr_q[ADDR_WIDTH-1:2];
      mem_idx    = word_idx[IDX_W-1:0];
      access_err = (addr_q[1:0] != 2'b00) ||
                   ({1'b0, word_idx} >= (ADDR_WIDTH-1)'(DEPTH_WORDS));
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and the one-cycle event strobes used by the datapath.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      resp_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               commit    = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_done = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign req_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_error = error_q;

   // Request latch, wait down-counter, and registered response payload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
      end else begin
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            cnt_q   <= 4'(WAIT_CYCLES);
         end else if (state == S_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (commit) begin
            error_q <= access_err;
            rdata_q <= (!access_err && !write_q) ? mem[mem_idx] : 32'd0;
         end else if (resp_done) begin
            error_q <= 1'b0;
            rdata_q <= 32'd0;
         end
      end
   end

   // Storage: byte-masked store, once per request, only at commit. Not reset.
   always_ff @(posedge clk) begin
      if (commit && write_q && !access_err) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance carries most scenarios,
// a WAIT_CYCLES=0 instance covers the minimum-latency build. Expected
// responses are queued at accept time and popped by per-instance monitors.

module tb_mem_responder;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   exp_t sb0[$];
   exp_t sb1[$];

   logic        reset0, req_valid0, req_ready0, req_write0;
   logic [31:0] req_addr0, req_wdata0, resp_rdata0;
   logic [3:0]  req_wstrb0;
   logic        resp_valid0, resp_ready0, resp_error0, busy0;

   logic        reset1, req_valid1, req_ready1, req_write1;
   logic [31:0] req_addr1, req_wdata1, resp_rdata1;
   logic [3:0]  req_wstrb1;
   logic        resp_valid1, resp_ready1, resp_error1, busy1;

   mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .reset(reset0),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_error(resp_error0), .busy(busy0)
   );

   mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset1),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_error(resp_error1), .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Monitor for dut0: compare the response payload on each handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!reset0 && resp_valid0 && resp_ready0) begin
         if (sb0.size() == 0) begin
            check("dut0_unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb0.pop_front();
            check("dut0_rdata", resp_rdata0, e.rdata);
            check("dut0_error", {31'd0, resp_error0}, {31'd0, e.err});
         end
      end
   end

   // Monitor for dut1.
   always @(negedge clk) begin
      exp_t e;
      if (!reset1 && resp_valid1 && resp_ready1) begin
         if (sb1.size() == 0) begin
            check("dut1_unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb1.pop_front();
            check("dut1_rdata", resp_rdata1, e.rdata);
            check("dut1_error", {31'd0, resp_error1}, {31'd0, e.err});
         end
      end
   end

   // Issue one request to dut0 (called just after a posedge, FSM idle),
   // queue its expected response and return once resp_valid is seen.
   task automatic issue0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rd,
                         input logic exp_err, input string name);
      int   cyc;
      exp_t e;
      req_write0 = wr;
      req_addr0  = addr;
      req_wdata0 = wdata;
      req_wstrb0 = strb;
      req_valid0 = 1'b1;
      check({name, "_req_ready"}, {31'd0, req_ready0}, 32'd1);
      @(posedge clk);
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb0.push_back(e);
      #1 req_valid0 = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!resp_valid0 && cyc < 50);
      check({name, "_latency"}, 32'(cyc), 32'd3);
      check({name, "_busy"}, {31'd0, busy0}, 32'd1);
   endtask

   // Let the handshake complete (resp_ready assumed high) and confirm IDLE.
   task automatic finish0(input string name);
      @(posedge clk);
      #1;
      check({name, "_idle_valid"}, {31'd0, resp_valid0}, 32'd0);
      check({name, "_idle_ready"}, {31'd0, req_ready0}, 32'd1);
      check({name, "_idle_busy"}, {31'd0, busy0}, 32'd0);
      check({name, "_idle_rdata"}, resp_rdata0, 32'd0);
   endtask

   // Request to the zero-wait instance with cycle-exact valid/busy checks.
   task automatic issue1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rd, input string name);
      exp_t e;
      req_write1 = wr;
      req_addr1  = addr;
      req_wdata1 = wdata;
      req_wstrb1 = strb;
      req_valid1 = 1'b1;
      check({name, "_req_ready"}, {31'd0, req_ready1}, 32'd1);
      @(posedge clk);
      e.rdata = exp_rd;
      e.err   = 1'b0;
      sb1.push_back(e);
      #1 req_valid1 = 1'b0;
      check({name, "_n_valid"}, {31'd0, resp_valid1}, 32'd0);
      check({name, "_n_busy"}, {31'd0, busy1}, 32'd1);
      @(posedge clk);
      #1;
      check({name, "_n1_valid"}, {31'd0, resp_valid1}, 32'd1);
      check({name, "_n1_busy"}, {31'd0, busy1}, 32'd1);
      @(posedge clk);
      #1;
      check({name, "_n2_valid"}, {31'd0, resp_valid1}, 32'd0);
      check({name, "_n2_busy"}, {31'd0, busy1}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset0 = 1'b1; reset1 = 1'b1;
      req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0; req_wstrb0 = 4'd0;
      req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 32'd0; req_wdata1 = 32'd0; req_wstrb1 = 4'd0;
      resp_ready0 = 1'b1; resp_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset0 = 1'b0; reset1 = 1'b0;
      check("rst_req_ready", {31'd0, req_ready0}, 32'd1);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_valid", {31'd0, resp_valid0}, 32'd0);
      check("rst_rdata", resp_rdata0, 32'd0);
      check("rst_error", {31'd0, resp_error0}, 32'd0);

      // Full store then load.
      issue0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st10");
      finish0("st10");
      issue0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10");
      finish0("ld10");

      // Byte-0 partial store.
      issue0(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, "pst10");
      finish0("pst10");
      issue0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "ld10b");
      finish0("ld10b");

      // Empty strobe is a no-op without error.
      issue0(1'b1, 32'h10, 32'h55555555, 4'h0, 32'h0, 1'b0, "st0strb");
      finish0("st0strb");

      // Misaligned load, out-of-range store, then no corruption.
      issue0(1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, "ld12");
      finish0("ld12");
      issue0(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st1000");
      finish0("st1000");
      issue0(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "st11");
      finish0("st11");
      issue0(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "stlast");
      finish0("stlast");
      issue0(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, "ldlast");
      finish0("ldlast");
      issue0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "ld10c");
      finish0("ld10c");

      // Back-pressured load response with an ignored request in the window.
      resp_ready0 = 1'b0;
      issue0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, resp_valid0}, 32'd1);
         check("bp_rdata", resp_rdata0, 32'hDEADBEAA);
         check("bp_error", {31'd0, resp_error0}, 32'd0);
         check("bp_req_ready", {31'd0, req_ready0}, 32'd0);
         if (i == 1) begin
            req_write0 = 1'b1; req_addr0 = 32'h10; req_wdata0 = 32'h11111111;
            req_wstrb0 = 4'hF; req_valid0 = 1'b1;
         end
         if (i == 2) req_valid0 = 1'b0;
      end
      @(posedge clk);
      #2 resp_ready0 = 1'b1;
      finish0("bp");
      issue0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "ld10d");
      finish0("ld10d");

      // Reset while a store sits in WAIT with counter > 0.
      issue0(1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, "pre20");
      finish0("pre20");
      req_write0 = 1'b1; req_addr0 = 32'h20; req_wdata0 = 32'h12345678;
      req_wstrb0 = 4'hF; req_valid0 = 1'b1;
      @(posedge clk);
      #1 req_valid0 = 1'b0;
      @(posedge clk);
      #1;
      check("rw_busy_before", {31'd0, busy0}, 32'd1);
      reset0 = 1'b1;
      #1;
      check("rw_busy", {31'd0, busy0}, 32'd0);
      check("rw_valid", {31'd0, resp_valid0}, 32'd0);
      check("rw_rdata", resp_rdata0, 32'd0);
      check("rw_error", {31'd0, resp_error0}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset0 = 1'b0;
      check("rw_req_ready", {31'd0, req_ready0}, 32'd1);
      issue0(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, "ld20");
      finish0("ld20");

      // Zero-wait instance.
      issue1(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, "w0st40");
      issue1(1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, "w0ld40");

      repeat (2) @(posedge clk);
      check("sb0_drained", 32'(sb0.size()), 32'd0);
      check("sb1_drained", 32'(sb1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
